// File: rtl/parcel_aligner_pkg.sv
// Shared types and constants for the parcel aligner: parcel type, FSM states
// and the compressed-parcel classifier.
package parcel_aligner_pkg;

    typedef logic [15:0] parcel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } aligner_state_t;

    localparam int          PARCEL_BYTES = 2;
    localparam logic [31:0] RESET_INSTR  = 32'h0000_0000;
    localparam parcel_t     NOOP_PARCEL  = 16'h0001;

    function automatic logic is_compressed(input parcel_t p);
        return (p[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/parcel_aligner_if.sv
// Decode-side instruction handshake of the parcel aligner.
// instr_illegal exists only when PARCEL_ALIGNER_ILLEGAL_CHECK_EN is defined.
interface parcel_aligner_if #(
    parameter int AW = 6
);
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [AW:0] instr_pc;
    logic        instr_compressed;
`ifdef PARCEL_ALIGNER_ILLEGAL_CHECK_EN
    logic        instr_illegal;

    modport master (output instr_valid, output instr, output instr_pc,
                    output instr_compressed, output instr_illegal, input instr_ready);
    modport slave  (input instr_valid, input instr, input instr_pc,
                    input instr_compressed, input instr_illegal, output instr_ready);
`else
    modport master (output instr_valid, output instr, output instr_pc,
                    output instr_compressed, input instr_ready);
    modport slave  (input instr_valid, input instr, input instr_pc,
                    input instr_compressed, output instr_ready);
`endif
endinterface

// File: rtl/parcel_aligner_fifo.sv
// Circular parcel buffer: single push, pop of one or two parcels, head and
// head+1 peek, and a flush that empties it in one edge.
module parcel_aligner_fifo
    import parcel_aligner_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  parcel_t       push_data,
    input  logic          pop1,
    input  logic          pop2,
    output logic [CW-1:0] count,
    output parcel_t       head,
    output parcel_t       head_next
);

    parcel_t       store_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] pop_amt_s;

    // Number of parcels leaving the head this cycle.
    always_comb begin
        pop_amt_s = {CW{1'b0}};
        if (pop2) begin
            pop_amt_s = CW'(2);
        end else if (pop1) begin
            pop_amt_s = CW'(1);
        end else begin
            pop_amt_s = {CW{1'b0}};
        end
    end

    // Pointers, occupancy and storage; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                store_r[i] <= NOOP_PARCEL;
            end
        end else if (flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                store_r[wr_ptr_r] <= push_data;
                wr_ptr_r          <= wr_ptr_r + PW'(1);
            end
            rd_ptr_r <= rd_ptr_r + pop_amt_s[PW-1:0];
            count_r  <= count_r + CW'(push) - pop_amt_s;
        end
    end

    assign count     = count_r;
    assign head      = store_r[rd_ptr_r];
    assign head_next = store_r[rd_ptr_r + PW'(1)];

endmodule

// File: rtl/parcel_aligner.sv
// Streams 16-bit parcels from instruction memory and reassembles 16/32-bit
// instructions for decode. Optional flag: PARCEL_ALIGNER_ILLEGAL_CHECK_EN.
module parcel_aligner
    import parcel_aligner_pkg::*;
#(
    parameter int                        IMEM_ADDRESS_WIDTH = 6,
    parameter logic [IMEM_ADDRESS_WIDTH:0] RESET_PC         = {(IMEM_ADDRESS_WIDTH+1){1'b0}},
    parameter int                        BUFFER_DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          mem_req,
    output logic [IMEM_ADDRESS_WIDTH-1:0] mem_addr,
    input  parcel_t                       mem_rdata,
    input  logic                          redirect_valid,
    input  logic [IMEM_ADDRESS_WIDTH:0]   redirect_pc,
    parcel_aligner_if.master              dec
);

    localparam int          AW       = IMEM_ADDRESS_WIDTH;
    localparam int          CW       = $clog2(BUFFER_DEPTH) + 1;
    localparam logic [AW:0] START_PC = {RESET_PC[AW:1], 1'b0};
    localparam logic [AW:0] STEP_C   = (AW+1)'(PARCEL_BYTES);
    localparam logic [AW:0] STEP_W   = (AW+1)'(2 * PARCEL_BYTES);

    aligner_state_t state_r;
    aligner_state_t state_nxt_s;
    logic [AW-1:0]  fetch_addr_r;
    logic [AW:0]    pc_r;
    logic           inflight_r;
    logic           discard_r;
    logic [CW-1:0]  count_s;
    parcel_t        head_s;
    parcel_t        head_next_s;
    logic           head_c_s;
    logic           valid_s;
    logic           accept_s;
    logic           issue_s;
    logic           push_s;
    logic           unused_pc_bit_s;

    assign unused_pc_bit_s = redirect_pc[0];

    parcel_aligner_fifo #(.DEPTH(BUFFER_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (mem_rdata),
        .pop1      (accept_s & head_c_s),
        .pop2      (accept_s & ~head_c_s),
        .count     (count_s),
        .head      (head_s),
        .head_next (head_next_s)
    );

    // Next-state logic: DRAIN covers a redirect that catches a read in flight.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = RUN;
            RUN: begin
                if (redirect_valid && inflight_r) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN:   state_nxt_s = RUN;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Credit-based issue, response push, and instruction assembly from the head.
    always_comb begin
        head_c_s = is_compressed(head_s);
        valid_s  = (((count_s != {CW{1'b0}}) && head_c_s) || (count_s >= CW'(2))) && !redirect_valid;
        accept_s = valid_s && dec.instr_ready;
        issue_s  = (state_r != IDLE) && !redirect_valid &&
                   ((count_s + CW'(inflight_r)) < CW'(BUFFER_DEPTH));
        push_s   = inflight_r && !discard_r && !redirect_valid;

        dec.instr_valid      = valid_s;
        dec.instr_pc         = pc_r;
        dec.instr_compressed = (count_s != {CW{1'b0}}) && head_c_s;
        if ((count_s != {CW{1'b0}}) && head_c_s) begin
            dec.instr = {16'h0000, head_s};
        end else if (count_s >= CW'(2)) begin
            dec.instr = {head_next_s, head_s};
        end else begin
            dec.instr = RESET_INSTR;
        end
`ifdef PARCEL_ALIGNER_ILLEGAL_CHECK_EN
        dec.instr_illegal = valid_s &&
            ((head_c_s && (head_s == 16'h0000)) ||
             (!head_c_s && ({head_next_s, head_s} == 32'hFFFF_FFFF)));
`endif
    end

    assign mem_req  = issue_s;
    assign mem_addr = fetch_addr_r;

    // State, fetch address, delivered PC and in-flight tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            fetch_addr_r <= START_PC[AW:1];
            pc_r         <= START_PC;
            inflight_r   <= 1'b0;
            discard_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            inflight_r <= issue_s;
            discard_r  <= redirect_valid && inflight_r;
            if (redirect_valid) begin
                fetch_addr_r <= redirect_pc[AW:1];
                pc_r         <= {redirect_pc[AW:1], 1'b0};
            end else begin
                if (issue_s) begin
                    fetch_addr_r <= fetch_addr_r + AW'(1);
                end
                if (accept_s) begin
                    pc_r <= pc_r + (head_c_s ? STEP_C : STEP_W);
                end
            end
        end
    end

endmodule

// File: tb/tb_parcel_aligner.sv
// Self-checking bench for parcel_aligner: vector table, hand-written corner
// sequences and a randomized run against a parcel-stream reference model.
module tb_parcel_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req;
    logic [5:0]  mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        redirect_valid = 1'b0;
    logic [6:0]  redirect_pc = 7'd0;
    logic [15:0] imem [64];

    int tests = 0;
    int fails = 0;

    parcel_aligner_if #(.AW(6)) dec_if ();

    parcel_aligner #(
        .IMEM_ADDRESS_WIDTH (6),
        .RESET_PC           (7'd0),
        .BUFFER_DEPTH       (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (dec_if)
    );

    always #5 clk = ~clk;

    // Instruction memory with fixed one-cycle read latency.
    always @(posedge clk) mem_rdata <= imem[mem_addr];

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        has_hi;
        logic [31:0] e_instr;
        logic [6:0]  e_pc;
        logic        e_c;
        logic        e_ill;
    } vec_t;

    vec_t vec [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        redirect_valid = 1'b0;
        #10;
        rst = 1'b1;
    endtask

    // Waits (bounded) for instr_valid with ready high and checks the instruction.
    task automatic expect_instr(input string nm, input logic [31:0] ei, input logic [6:0] ep,
                                input logic ec, input logic eill);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (dec_if.instr_valid) seen = 1'b1;
        end
        check({nm, " valid"}, 32'(seen), 32'd1);
        if (seen) begin
            check({nm, " instr"}, dec_if.instr, ei);
            check({nm, " pc"}, 32'(dec_if.instr_pc), 32'(ep));
            check({nm, " compressed"}, 32'(dec_if.instr_compressed), 32'(ec));
`ifdef PARCEL_ALIGNER_ILLEGAL_CHECK_EN
            check({nm, " illegal"}, 32'(dec_if.instr_illegal), 32'(eill));
`else
            if (eill !== 1'b0 && eill !== 1'b1) check({nm, " illegal arg"}, 32'(eill), 32'd0);
`endif
        end
    endtask

    // Reference: instruction starting at byte pc in the parcel memory.
    function automatic void ref_fetch(input logic [6:0] pc, output logic [31:0] ins,
                                      output logic [6:0] len);
        logic [5:0]  idx;
        logic [15:0] lo;
        logic [15:0] hi;
        idx = pc[6:1];
        lo  = imem[idx];
        hi  = imem[idx + 6'd1];
        if (lo[1:0] != 2'b11) begin
            ins = {16'h0000, lo};
            len = 7'd2;
        end else begin
            ins = {hi, lo};
            len = 7'd4;
        end
    endfunction

    task automatic load_table();
        int p = 0;
        for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            imem[p] = vec[i].lo;
            p++;
            if (vec[i].has_hi) begin
                imem[p] = vec[i].hi;
                p++;
            end
        end
    endtask

    initial begin
        logic [31:0] hold_instr;
        logic [6:0]  hold_pc;
        logic [31:0] ei;
        logic [6:0]  len;
        logic [6:0]  model_pc;
        bit          held;
        int          reqs;
        int          got;

        vec[0] = '{16'h4501, 16'h0000, 1'b0, 32'h0000_4501, 7'd0,  1'b1, 1'b0};
        vec[1] = '{16'h0093, 16'h0010, 1'b1, 32'h0010_0093, 7'd2,  1'b0, 1'b0};
        vec[2] = '{16'h0000, 16'h0000, 1'b0, 32'h0000_0000, 7'd6,  1'b1, 1'b1};
        vec[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFF_FFFF, 7'd8,  1'b0, 1'b1};
        vec[4] = '{16'h8082, 16'h0000, 1'b0, 32'h0000_8082, 7'd12, 1'b1, 1'b0};
        vec[5] = '{16'h0513, 16'h0000, 1'b1, 32'h0000_0513, 7'd14, 1'b0, 1'b0};
        vec[6] = '{16'h0001, 16'h0000, 1'b0, 32'h0000_0001, 7'd18, 1'b1, 1'b0};
        vec[7] = '{16'h0002, 16'h0000, 1'b0, 32'h0000_0002, 7'd20, 1'b1, 1'b0};

        dec_if.instr_ready = 1'b1;
        load_table();

        // Reset values while held in reset.
        #2;
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset valid", 32'(dec_if.instr_valid), 32'd0);
        check("reset pc", 32'(dec_if.instr_pc), 32'd0);
        check("reset instr", dec_if.instr, 32'd0);
        check("reset compressed", 32'(dec_if.instr_compressed), 32'd0);

        // Table: in-order delivery with ready held high.
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            expect_instr($sformatf("vec%0d", i), vec[i].e_instr, vec[i].e_pc, vec[i].e_c, vec[i].e_ill);
        end

        // Backpressure: four reads then stall, outputs held, then ordered release.
        dec_if.instr_ready = 1'b0;
        apply_reset();
        reqs = 0;
        held = 1'b0;
        hold_instr = 32'd0;
        hold_pc = 7'd0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_req) reqs++;
            if (dec_if.instr_valid) begin
                if (!held) begin
                    held = 1'b1;
                    hold_instr = dec_if.instr;
                    hold_pc = dec_if.instr_pc;
                end else begin
                    check("bp hold instr", dec_if.instr, hold_instr);
                    check("bp hold pc", 32'(dec_if.instr_pc), 32'(hold_pc));
                end
            end
        end
        check("bp reads", 32'(reqs), 32'd4);
        check("bp valid", 32'(dec_if.instr_valid), 32'd1);
        check("bp held instr", hold_instr, 32'h0000_4501);
        @(posedge clk); #1;
        dec_if.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_instr($sformatf("bp%0d", i), vec[i].e_instr, vec[i].e_pc, vec[i].e_c, vec[i].e_ill);
        end

        // Wrap: 32-bit instruction split across parcel 63 and parcel 0.
        for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
        imem[63] = 16'h0093;
        imem[0]  = 16'h0010;
        imem[1]  = 16'h4501;
        apply_reset();
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 7'd126;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        expect_instr("wrap", 32'h0010_0093, 7'd126, 1'b0, 1'b0);
        expect_instr("wrap next", 32'h0000_4501, 7'd2, 1'b1, 1'b0);

        // Redirect with a read in flight and a simultaneous accept attempt.
        load_table();
        apply_reset();
        held = 1'b0;
        for (int n = 0; n < 20 && !held; n++) begin
            @(negedge clk);
            if (dec_if.instr_valid) held = 1'b1;
        end
        check("redir pre valid", 32'(held), 32'd1);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 7'd21;
        @(negedge clk);
        check("redir gate valid", 32'(dec_if.instr_valid), 32'd0);
        check("redir gate req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir first req", 32'(mem_req), 32'd1);
        check("redir first addr", 32'(mem_addr), 32'd10);
        expect_instr("redir tgt", 32'h0000_0002, 7'd20, 1'b1, 1'b0);
        expect_instr("redir tgt+1", 32'h0000_0000, 7'd22, 1'b1, 1'b1);

        // Short asynchronous reset pulse mid-stream.
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("areset valid", 32'(dec_if.instr_valid), 32'd0);
        check("areset req", 32'(mem_req), 32'd0);
        check("areset addr", 32'(mem_addr), 32'd0);
        check("areset pc", 32'(dec_if.instr_pc), 32'd0);
        check("areset instr", dec_if.instr, 32'd0);
        #2;
        rst = 1'b1;
        expect_instr("areset restart", 32'h0000_4501, 7'd0, 1'b1, 1'b0);

        // Random memory, random backpressure and redirects against the model.
        for (int i = 0; i < 64; i++) imem[i] = 16'($urandom);
        apply_reset();
        model_pc = 7'd0;
        got = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            dec_if.instr_ready = ($urandom_range(0, 3) != 0);
            if (cyc > 5 && $urandom_range(0, 31) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = 7'($urandom_range(0, 127));
            end else begin
                redirect_valid = 1'b0;
            end
            @(negedge clk);
            if (redirect_valid) begin
                check("rnd redirect gate", 32'(dec_if.instr_valid), 32'd0);
                model_pc = redirect_pc & 7'h7E;
            end else if (dec_if.instr_valid && dec_if.instr_ready) begin
                ref_fetch(model_pc, ei, len);
                check("rnd instr", dec_if.instr, ei);
                check("rnd pc", 32'(dec_if.instr_pc), 32'(model_pc));
                check("rnd compressed", 32'(dec_if.instr_compressed), 32'(len == 7'd2));
                model_pc = model_pc + len;
                got++;
            end
        end
        redirect_valid = 1'b0;
        check("rnd progress", 32'(got >= 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
